ppm_encoder: RTL and testbench
==============================

# ppm_encoder

Transmit-side 1-of-4 pulse-position modulator; the line partner of the SOF detector and PPM decoder, and the source of their stimulus. It accepts bytes over a valid/ready stream and drives a single idle-high line `Dout` with a frame: SOF, then 1-of-4 PPM data symbols, optionally a CRC-16, then EOF, then a guard gap. It runs on the 16x oversampling clock `clk16`, so its output timing is in the decoder's sample units.

## Interface
- `PULSE_W`, 1: width in `clk16` cycles of each data or SOF low pulse.
- `SLOT_W`, 4: slot length in cycles. One symbol is 4 slots; one byte is 16 slots.
- `SOF_GAP`, 5: start-to-start spacing of the two SOF pulses.
- `EOF_W`, 3: low width of the EOF marker.
- `GUARD`, 16: minimum number of idle-high cycles after EOF.
- `clk16` input 1: the only clock.
- `rst` input 1: synchronous, active-high reset.
- `tx_data` input 8: payload byte.
- `tx_valid` input 1: `tx_data` and `tx_last` are valid.
- `tx_last` input 1: the byte is the final payload byte of the frame.
- `tx_ready` output 1: the byte is accepted in any cycle where `tx_valid && tx_ready`.
- `Dout` output 1: PPM line. Idle and reset value is 1.
- `busy` output 1: high from the cycle after the first handshake until the guard gap ends.
- `underrun` output 1: one-cycle pulse when the source starves mid-frame.

## Operation
- State machine: IDLE → SOF → DATA → (CRC) → EOF → GUARD → IDLE.
- **IDLE:** `tx_ready=1` and `Dout=1`. A handshake latches the byte and `tx_last`, then moves to SOF.
- **SOF:** low pulses start at SOF cycles 0 and `SOF_GAP`. The state lasts 2·`SOF_GAP` cycles.
  - The spacing of 5 is never a multiple of `SLOT_W`, so SOF cannot be confused with data.
- **DATA:** each byte is sent as 4 symbols, least-significant pair first: bits [1:0], [3:2], [5:4], [7:6].
  - Symbol value v puts a `PULSE_W` low pulse at the start of slot v.
  - `Dout` is high for the rest of the symbol.
- **Byte boundary:** `tx_ready=1` only in the final cycle of a non-last byte.
  - Handshake in that cycle: the next byte's first symbol follows with no gap.
  - `tx_valid=0` in that cycle: pulse `underrun`, skip CRC, go to EOF.
- **After the last byte:** go to CRC if it is compiled in, otherwise to EOF.
- **EOF:** `Dout` low for `EOF_W` cycles. This width never occurs in data.
- **GUARD:** `Dout` high for `GUARD` cycles with `tx_ready=0`, then IDLE.
- `tx_ready=0` in all cycles other than IDLE and byte-boundary cycles. `tx_valid` is ignored there.
- **Reset mid-frame:** on the next edge `Dout=1`, `busy=0`, `underrun=0` and the state is IDLE. No EOF is sent.
  - `tx_ready` is 0 while `rst` is high and 1 in the first cycle after release.

## Timing
Cycle numbers below count from the handshake edge, cycle 0, with default parameters.
- SOF pulses are low in cycles 1 and 6.
- The first symbol starts in cycle 11. Symbol k of byte n starts at 11 + 64n + 16k.
- The final cycle of byte n, and its `tx_ready` window, is 74 + 64n.
- For an N-byte frame without CRC, EOF is low in cycles 11+64N through 13+64N.
- The guard gap occupies the next 16 cycles. IDLE and `tx_ready=1` follow in cycle 30+64N.
- `Dout` is registered. It has no combinational path from inputs.

## Configuration
- `PPM_TX_CRC_EN` defined: after the last byte, append a CRC-16 as two bytes, high byte first, each byte LSB pair first.
  - CRC parameters: polynomial 0x1021, init 0xFFFF, MSB-first per byte, no reflection, no final XOR.
  - The CRC covers payload bytes only. An underrun skips the CRC.
- Not defined: EOF follows the last payload byte directly, and no CRC logic is instantiated.

## Structure
- Package `ppm_pkg` holds:
  - the state enum;
  - default `PULSE_W`, `SLOT_W`, `SOF_GAP`, `EOF_W` and `GUARD`, shared with the decoder and SOF detector;
  - the CRC polynomial and init value.
- Sub-module `ppm_crc16`: a byte-wide combinational update with a registered accumulator, cleared at SOF. It is instantiated only under `PPM_TX_CRC_EN`.

## Test plan
- **Reset:** hold `rst` high for 2 cycles → `Dout=1`, `busy=0`, `underrun=0`, `tx_ready=0`; then `tx_ready=1` in the first cycle after release.
- **Single byte:** 0xE4 with `tx_last=1` → `Dout` low in cycles 1, 6, 11, 31, 51, 71 and 75–77; IDLE with `tx_ready=1` in cycle 94.
- **Three bytes back-to-back:** 0x00, 0xFF, 0x1B → `tx_ready` pulses in cycles 74 and 138 only. Pulse spacing across byte boundaries stays on the slot grid, and EOF starts in cycle 203.
- **Underrun:** first byte with `tx_last=0`, then `tx_valid` low in cycle 74 → `underrun` high in cycle 74 only, and EOF low in cycles 75–77.
- **CRC:** ASCII "123456789" with `PPM_TX_CRC_EN` defined → symbols for 0x29 then 0xB1 follow byte 9, then EOF. Without the macro, EOF follows byte 9 directly.
- **Reset mid-frame:** assert `rst` in cycle 40 of a frame → `Dout=1` from cycle 41 with no EOF. A following frame starts with a clean SOF.

Source files
------------

// File: rtl/ppm_pkg.sv
// Shared definitions for the 1-of-4 PPM line: state encoding, default line timing
// and the CRC-16 (poly 0x1021, init 0xFFFF, MSB-first) byte update.
package ppm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_DATA,
    ST_CRC,
    ST_EOF,
    ST_GUARD
  } ppm_state_e;

  localparam int unsigned PPM_PULSE_W = 1;
  localparam int unsigned PPM_SLOT_W  = 4;
  localparam int unsigned PPM_SOF_GAP = 5;
  localparam int unsigned PPM_EOF_W   = 3;
  localparam int unsigned PPM_GUARD   = 16;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  function automatic logic [15:0] crc16Byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = {c[14:0], 1'b0} ^ (c[15] ? CRC16_POLY : 16'h0000);
    end
    return c;
  endfunction

endpackage

// File: rtl/ppm_crc16.sv
// Byte-wide CRC-16 accumulator for the PPM transmitter; clear_i reseeds with the
// init value and may coincide with en_i so the first byte folds into a fresh CRC.
module ppm_crc16
  import ppm_pkg::*;
(
  input  logic        clk16_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q, crc_d;
  logic [15:0] base;

  always_comb begin
    base  = clear_i ? CRC16_INIT : crc_q;
    crc_d = base;
    if (en_i) begin
      crc_d = crc16Byte(base, data_i);
    end
  end

  always_ff @(posedge clk16_i) begin
    if (rst_i) begin
      crc_q <= CRC16_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/ppm_encoder.sv
// 1-of-4 PPM frame transmitter: SOF, LSB-pair-first data symbols, optional CRC-16,
// EOF and guard gap on an idle-high line. Optional CRC: define PPM_TX_CRC_EN.
module ppm_encoder
  import ppm_pkg::*;
#(
  parameter int unsigned PULSE_W = PPM_PULSE_W,
  parameter int unsigned SLOT_W  = PPM_SLOT_W,
  parameter int unsigned SOF_GAP = PPM_SOF_GAP,
  parameter int unsigned EOF_W   = PPM_EOF_W,
  parameter int unsigned GUARD   = PPM_GUARD
) (
  input  logic       clk16,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       Dout,
  output logic       busy,
  output logic       underrun
);

  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] SOF_LAST   = CW'(2 * SOF_GAP - 1);
  localparam logic [CW-1:0] GAP        = CW'(SOF_GAP);
  localparam logic [CW-1:0] GAP_END    = CW'(SOF_GAP + PULSE_W);
  localparam logic [CW-1:0] PW         = CW'(PULSE_W);
  localparam logic [CW-1:0] SLOT       = CW'(SLOT_W);
  localparam logic [CW-1:0] SYM_LAST   = CW'(4 * SLOT_W - 1);
  localparam logic [CW-1:0] EOF_LAST   = CW'(EOF_W - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);

  // cnt_q counts cycles within SOF/EOF/GUARD and the offset within a symbol in DATA/CRC
  ppm_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sym_q, sym_d;
  logic [7:0]    byte_q, byte_d;
  logic          last_q, last_d;
  logic          dout_q, dout_d;

  logic          symEnd;
  logic          byteEnd;
  logic          accept;
  logic [1:0]    symVal;
  logic [CW-1:0] slotStart;

`ifdef PPM_TX_CRC_EN
  logic          crcLo_q, crcLo_d;
  logic [15:0]   crcVal;

  ppm_crc16 u_crc (
    .clk16_i (clk16),
    .rst_i   (rst),
    .clear_i (state_q == ST_IDLE),
    .en_i    (accept),
    .data_i  (tx_data),
    .crc_o   (crcVal)
  );
`endif

  always_comb begin
    symEnd   = (cnt_q == SYM_LAST);
    byteEnd  = symEnd && (sym_q == 2'd3);
    tx_ready = !rst && ((state_q == ST_IDLE) ||
                        ((state_q == ST_DATA) && byteEnd && !last_q));
    accept   = tx_ready && tx_valid;
    underrun = tx_ready && (state_q == ST_DATA) && !tx_valid;
    busy     = (state_q != ST_IDLE);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    sym_d   = sym_q;
    byte_d  = byte_q;
    last_d  = last_q;
`ifdef PPM_TX_CRC_EN
    crcLo_d = crcLo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        sym_d = '0;
        if (accept) begin
          state_d = ST_SOF;
          byte_d  = tx_data;
          last_d  = tx_last;
        end
      end
      ST_SOF: begin
        if (cnt_q == SOF_LAST) begin
          state_d = ST_DATA;
          cnt_d   = '0;
          sym_d   = '0;
        end
      end
      ST_DATA: begin
        if (symEnd) begin
          cnt_d = '0;
          sym_d = sym_q + 2'd1;
          if (byteEnd) begin
            if (!last_q) begin
              // a starved source ends the frame early without a CRC
              if (accept) begin
                byte_d = tx_data;
                last_d = tx_last;
              end else begin
                state_d = ST_EOF;
              end
            end else begin
`ifdef PPM_TX_CRC_EN
              state_d = ST_CRC;
              byte_d  = crcVal[15:8];
              crcLo_d = 1'b0;
`else
              state_d = ST_EOF;
`endif
            end
          end
        end
      end
`ifdef PPM_TX_CRC_EN
      ST_CRC: begin
        if (symEnd) begin
          cnt_d = '0;
          sym_d = sym_q + 2'd1;
          if (byteEnd) begin
            if (!crcLo_q) begin
              byte_d  = crcVal[7:0];
              crcLo_d = 1'b1;
            end else begin
              state_d = ST_EOF;
            end
          end
        end
      end
`endif
      ST_EOF: begin
        if (cnt_q == EOF_LAST) begin
          state_d = ST_GUARD;
          cnt_d   = '0;
        end
      end
      ST_GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // The line level is decoded from the next state so Dout comes straight off a flop
  always_comb begin
    case (sym_d)
      2'd0:    symVal = byte_d[1:0];
      2'd1:    symVal = byte_d[3:2];
      2'd2:    symVal = byte_d[5:4];
      default: symVal = byte_d[7:6];
    endcase
    slotStart = CW'(symVal) * SLOT;
    dout_d    = 1'b1;
    case (state_d)
      ST_SOF:          dout_d = !((cnt_d < PW) || ((cnt_d >= GAP) && (cnt_d < GAP_END)));
      ST_DATA, ST_CRC: dout_d = !((cnt_d >= slotStart) && (cnt_d < slotStart + PW));
      ST_EOF:          dout_d = 1'b0;
      default:         dout_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk16) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sym_q   <= '0;
      byte_q  <= '0;
      last_q  <= 1'b0;
      dout_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sym_q   <= sym_d;
      byte_q  <= byte_d;
      last_q  <= last_d;
      dout_q  <= dout_d;
    end
  end

`ifdef PPM_TX_CRC_EN
  always_ff @(posedge clk16) begin
    if (rst) begin
      crcLo_q <= 1'b0;
    end else begin
      crcLo_q <= crcLo_d;
    end
  end
`endif

  assign Dout = dout_q;

endmodule

// File: tb/tb_ppm_encoder.sv
// Self-checking bench for ppm_encoder: a table of frames with hand-computed EOF/IDLE
// cycles, per-cycle line traces checked against the published timing, plus reset cases.
`timescale 1ns/1ps
module tb_ppm_encoder;

  logic       clk16 = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_ready;
  logic       Dout;
  logic       busy;
  logic       underrun;

  always #5 clk16 = ~clk16;

  ppm_encoder dut (
    .clk16    (clk16),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_last  (tx_last),
    .tx_ready (tx_ready),
    .Dout     (Dout),
    .busy     (busy),
    .underrun (underrun)
  );

  typedef struct {
    string       name;
    int          nBytes;
    logic [71:0] payload;
    logic        underrunEnd;
    int          eofStart;
    int          idleCycle;
    logic [15:0] crcExp;
  } frame_t;

  localparam int MAXC = 1024;

  frame_t     frames[4];
  int         testsRun = 0;
  int         testsFailed = 0;
  logic       doutTr[MAXC];
  logic       readyTr[MAXC];
  logic       busyTr[MAXC];
  logic       underTr[MAXC];
  logic [7:0] sent[12];
  int         nSent;

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

`ifdef PPM_TX_CRC_EN
  // Bit-serial reference CRC used for frames whose CRC is not hand-known
  function automatic logic [15:0] tbCrc(input logic [71:0] p, input int n);
    logic [15:0] c;
    logic [7:0]  b;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      b = p[8*i +: 8];
      for (int j = 7; j >= 0; j--) begin
        fb = c[15] ^ b[j];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction
`endif

  function automatic logic expDout(input int c);
    logic [7:0] t;
    int         v;
    if (c == 1 || c == 6) return 1'b0;
    for (int n = 0; n < nSent; n++) begin
      for (int k = 0; k < 4; k++) begin
        t = sent[n] >> (2 * k);
        v = int'(t[1:0]);
        if (c == 11 + 64 * n + 16 * k + 4 * v) return 1'b0;
      end
    end
    if (c >= 11 + 64 * nSent && c <= 13 + 64 * nSent) return 1'b0;
    return 1'b1;
  endfunction

  // Handshake the frame in cycle 0 and record every output for the whole frame
  task automatic applyStimulus(input frame_t f);
    int idx;
    idx = 0;
    for (int c = 0; c <= f.idleCycle + 2; c++) begin
      @(posedge clk16);
      #1;
      tx_valid = (idx < f.nBytes);
      tx_data  = (idx < f.nBytes) ? f.payload[8*idx +: 8] : 8'h00;
      tx_last  = (idx == f.nBytes - 1) && !f.underrunEnd;
      #1;
      doutTr[c]  = Dout;
      readyTr[c] = tx_ready;
      busyTr[c]  = busy;
      underTr[c] = underrun;
      if (tx_valid && tx_ready) idx++;
    end
    tx_valid = 1'b0;
  endtask

  task automatic checkFrame(input frame_t f);
    int   eofS, idleC, last, bad, firstBad, expI, actI;
    logic e;
    eofS  = f.eofStart;
    idleC = f.idleCycle;
    nSent = f.nBytes;
    for (int i = 0; i < f.nBytes; i++) sent[i] = f.payload[8*i +: 8];
`ifdef PPM_TX_CRC_EN
    if (!f.underrunEnd) begin
      sent[nSent]     = f.crcExp[15:8];
      sent[nSent + 1] = f.crcExp[7:0];
      nSent += 2;
      eofS  += 128;
      idleC += 128;
    end
`endif
    last = idleC + 2;
    for (int kind = 0; kind < 4; kind++) begin
      bad = 0; firstBad = -1; expI = 0; actI = 0;
      for (int c = 0; c <= last; c++) begin
        case (kind)
          0: e = expDout(c);
          1: begin
            e = (c == 0) || (c >= idleC);
            for (int n = 0; n < f.nBytes; n++)
              if ((n < f.nBytes - 1 || f.underrunEnd) && c == 74 + 64 * n) e = 1'b1;
          end
          2: e = (c >= 1) && (c < idleC);
          default: e = f.underrunEnd && (c == 74 + 64 * (f.nBytes - 1));
        endcase
        case (kind)
          0: actI = int'(doutTr[c]);
          1: actI = int'(readyTr[c]);
          2: actI = int'(busyTr[c]);
          default: actI = int'(underTr[c]);
        endcase
        if (actI != int'(e)) begin
          if (firstBad < 0) begin firstBad = c; expI = int'(e); end
          bad++;
        end
      end
      checkOutput($sformatf("%s %s bad cycles (first at %0d, want %0d)", f.name,
                  kind == 0 ? "Dout" : kind == 1 ? "tx_ready" : kind == 2 ? "busy" : "underrun",
                  firstBad, expI), bad, 0);
    end
    checkOutput({f.name, " Dout before EOF"}, int'(doutTr[eofS - 1]), 1);
    checkOutput({f.name, " EOF low first"},   int'(doutTr[eofS]), 0);
    checkOutput({f.name, " EOF low last"},    int'(doutTr[eofS + 2]), 0);
    checkOutput({f.name, " Dout after EOF"},  int'(doutTr[eofS + 3]), 1);
    checkOutput({f.name, " tx_ready end of guard"}, int'(readyTr[idleC - 1]), 0);
    checkOutput({f.name, " tx_ready back in IDLE"}, int'(readyTr[idleC]), 1);
  endtask

  initial begin
    int lowCount;

    frames[0] = '{"single E4",   1, 72'hE4,                   1'b0,  75,  94, 16'h0000};
    frames[1] = '{"three bytes", 3, 72'h1BFF00,               1'b0, 203, 222, 16'h0000};
    frames[2] = '{"underrun",    1, 72'h5A,                   1'b1,  75,  94, 16'h0000};
    frames[3] = '{"ascii 1-9",   9, 72'h393837363534333231,   1'b0, 587, 606, 16'h29B1};
`ifdef PPM_TX_CRC_EN
    frames[0].crcExp = tbCrc(frames[0].payload, 1);
    frames[1].crcExp = tbCrc(frames[1].payload, 3);
`endif

    // Reset held for two edges, then released
    for (int i = 0; i < 2; i++) begin
      @(posedge clk16);
      #2;
      checkOutput("reset Dout", int'(Dout), 1);
      checkOutput("reset busy", int'(busy), 0);
      checkOutput("reset underrun", int'(underrun), 0);
      checkOutput("reset tx_ready", int'(tx_ready), 0);
    end
    @(posedge clk16);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("tx_ready after release", int'(tx_ready), 1);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(frames[i]);
      checkFrame(frames[i]);
    end

    // Reset asserted in cycle 40 of a frame: line returns high with no EOF
    lowCount = 0;
    for (int c = 0; c <= 110; c++) begin
      @(posedge clk16);
      #1;
      tx_valid = (c == 0);
      tx_data  = 8'hE4;
      tx_last  = 1'b1;
      if (c == 40) rst = 1'b1;
      if (c == 42) rst = 1'b0;
      #1;
      if (c == 0)  checkOutput("midreset handshake ready", int'(tx_ready), 1);
      if (c == 11) checkOutput("midreset first symbol", int'(Dout), 0);
      if (c == 41) begin
        checkOutput("midreset Dout", int'(Dout), 1);
        checkOutput("midreset busy", int'(busy), 0);
        checkOutput("midreset underrun", int'(underrun), 0);
        checkOutput("midreset tx_ready in reset", int'(tx_ready), 0);
      end
      if (c == 42) checkOutput("midreset tx_ready after release", int'(tx_ready), 1);
      if (c >= 41 && !Dout) lowCount++;
    end
    tx_valid = 1'b0;
    checkOutput("midreset no EOF low cycles", lowCount, 0);

    applyStimulus(frames[0]);
    checkFrame(frames[0]);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
